// File: rtl/pulse_frame_scheduler.sv
// Servo period / frame sequencer for the left and right drive modulators.
// Commands are staged per channel and applied only at frame boundaries.
module pulse_frame_scheduler #(
  parameter int PERIOD_CYCLES   = 2000000,
  parameter int NUM_STATES      = 24,
  parameter int LEAD_CYCLES     = 4,
  parameter int MIN_PULSE       = 100000,
  parameter int MAX_PULSE       = 200000,
  parameter int NEUTRAL_PULSE   = 150000,
  parameter int TIMEOUT_PERIODS = 50
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdChan,
  input  logic [4:0]  CmdModInfo,
  output logic [4:0]  ModInfoL,
  output logic [4:0]  ModInfoR,
  output logic [4:0]  State,
  output logic        PeriodStart,
  input  logic [20:0] PulseL,
  input  logic [20:0] PulseR,
  output logic        ServoL,
  output logic        ServoR
);
  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [4:0] NEUTRAL = 5'b00001;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          wrap;
  logic          frame_end;
  logic          latch;
  logic [31:0]   pos;

  assign wrap      = (cnt == CW'(PERIOD_CYCLES - 1));
  assign frame_end = wrap && (State == 5'(NUM_STATES - 1));
  assign latch     = (cnt == CW'(LEAD_CYCLES - 1));
  assign cnt_nx    = wrap ? '0 : cnt + CW'(1);
  assign pos       = 32'(cnt_nx);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt         <= '0;
      State       <= '0;
      PeriodStart <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      PeriodStart <= wrap;
      if (wrap)
        State <= frame_end ? '0 : State + 5'd1;
    end
  end

  logic [20:0] pulse   [2];
  logic [4:0]  mod_v   [2];
  logic        servo_v [2];
  logic        pend_v  [2];

  assign pulse[0] = PulseL;
  assign pulse[1] = PulseR;
  assign ModInfoL = mod_v[0];
  assign ModInfoR = mod_v[1];
  assign ServoL   = servo_v[0];
  assign ServoR   = servo_v[1];
  assign CmdReady = ~pend_v[CmdChan];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [4:0]    mod_q;
    logic [4:0]    pend_val;
    logic          pend;
    logic          servo_q;
    logic [WW-1:0] wd;
    logic [20:0]   width;
    logic [20:0]   wclamp;
    logic [20:0]   weff;
    logic          acc;
    logic          timeout;
    logic [31:0]   hi;

    assign acc     = CmdValid && !pend && (CmdChan == 1'(g));
    assign timeout = wrap && (wd == WW'(TIMEOUT_PERIODS - 1));
    assign mod_v[g]   = mod_q;
    assign servo_v[g] = servo_q;
    assign pend_v[g]  = pend;

    always_comb begin
      wclamp = pulse[g];
      if (pulse[g] < 21'(MIN_PULSE))
        wclamp = 21'(MIN_PULSE);
      else if (pulse[g] > 21'(MAX_PULSE))
        wclamp = 21'(MAX_PULSE);
    end

    // the latch edge already drives the first high cycle, so bypass the register
    assign weff = latch ? wclamp : width;
    assign hi   = 32'(LEAD_CYCLES) + 32'(weff);

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        mod_q    <= NEUTRAL;
        pend     <= 1'b0;
        pend_val <= '0;
        servo_q  <= 1'b0;
        wd       <= '0;
        width    <= 21'(NEUTRAL_PULSE);
      end else begin
        if (latch)
          width <= wclamp;
        servo_q <= (pos >= 32'(LEAD_CYCLES)) && (pos < hi);
        if (acc)
          wd <= '0;
        else if (wrap && (wd != WW'(TIMEOUT_PERIODS)))
          wd <= wd + WW'(1);
        // timeout overrides the boundary copy; a same-cycle command is kept
        if (timeout) begin
          mod_q <= NEUTRAL;
          pend  <= acc;
          if (acc)
            pend_val <= CmdModInfo;
        end else if (frame_end && pend) begin
          mod_q <= pend_val;
          pend  <= 1'b0;
        end else if (frame_end && acc) begin
          mod_q <= CmdModInfo;
        end else if (acc) begin
          pend     <= 1'b1;
          pend_val <= CmdModInfo;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_frame_scheduler.sv
// Bench for pulse_frame_scheduler with short sim periods.
// Reference model derives cnt/State from the cycle count since reset.
module tb_pulse_frame_scheduler;
  localparam int P    = 200;
  localparam int NS   = 4;
  localparam int LEAD = 4;
  localparam int MINP = 20;
  localparam int MAXP = 80;
  localparam int NEU  = 50;
  localparam int TMO  = 6;
  localparam int FR   = P * NS;

  logic        CLK;
  logic        RST_n;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdChan;
  logic [4:0]  CmdModInfo;
  logic [4:0]  ModInfoL;
  logic [4:0]  ModInfoR;
  logic [4:0]  State;
  logic        PeriodStart;
  logic [20:0] PulseL;
  logic [20:0] PulseR;
  logic        ServoL;
  logic        ServoR;

  int passed = 0;
  int total  = 0;
  bit mon_en = 0;
  int ka;

  pulse_frame_scheduler #(
    .PERIOD_CYCLES(P), .NUM_STATES(NS), .LEAD_CYCLES(LEAD),
    .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .NEUTRAL_PULSE(NEU),
    .TIMEOUT_PERIODS(TMO)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .CmdValid(CmdValid),
    .CmdReady(CmdReady), .CmdChan(CmdChan),
    .CmdModInfo(CmdModInfo), .ModInfoL(ModInfoL),
    .ModInfoR(ModInfoR), .State(State),
    .PeriodStart(PeriodStart), .PulseL(PulseL),
    .PulseR(PulseR), .ServoL(ServoL), .ServoR(ServoR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model state: k = clock edges since reset release
  int         k;
  logic [4:0] mq [2];
  bit         pf [2];
  logic [4:0] pv [2];
  int         la [2];
  int         wl [2];

  function automatic int clampw(input int p);
    return (p < MINP) ? MINP : ((p > MAXP) ? MAXP : p);
  endfunction

  // period wraps seen on edges a+1..kk
  function automatic int wraps(input int a, input int kk);
    return (kk + 1) / P - (a + 1) / P;
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      k = 0;
      for (int ch = 0; ch < 2; ch++) begin
        mq[ch] = 5'b00001;
        pf[ch] = 1'b0;
        pv[ch] = '0;
        la[ch] = -1;
        wl[ch] = NEU;
      end
    end else begin
      int c;
      bit pe;
      bit fe;
      c  = k % P;
      pe = (c == P - 1);
      fe = pe && ((k / P) % NS == NS - 1);
      if (c == LEAD - 1) begin
        wl[0] = clampw(int'(PulseL));
        wl[1] = clampw(int'(PulseR));
      end
      for (int ch = 0; ch < 2; ch++) begin
        bit acc;
        bit to;
        acc = CmdValid && (int'(CmdChan) == ch) && !pf[ch];
        to  = pe && (wraps(la[ch], k) == TMO);
        if (to) begin
          mq[ch] = 5'b00001;
          pf[ch] = acc;
          if (acc) pv[ch] = CmdModInfo;
        end else if (fe && pf[ch]) begin
          mq[ch] = pv[ch];
          pf[ch] = 1'b0;
        end else if (fe && acc) begin
          mq[ch] = CmdModInfo;
        end else if (acc) begin
          pf[ch] = 1'b1;
          pv[ch] = CmdModInfo;
        end
        if (acc) la[ch] = k;
      end
      k++;
    end
  end

  always @(negedge CLK) begin
    int c;
    logic e;
    if (mon_en && RST_n === 1'b1) begin
      c = k % P;
      total++;
      if (State !== 5'((k / P) % NS))
        $display("FAIL state k=%0d: got %0d want %0d", k, State, (k / P) % NS);
      else passed++;
      e = (k > 0) && (c == 0);
      total++;
      if (PeriodStart !== e)
        $display("FAIL period_start k=%0d: got %b want %b", k, PeriodStart, e);
      else passed++;
      e = (c >= LEAD) && (c < LEAD + wl[0]);
      total++;
      if (ServoL !== e)
        $display("FAIL servo_l k=%0d: got %b want %b", k, ServoL, e);
      else passed++;
      e = (c >= LEAD) && (c < LEAD + wl[1]);
      total++;
      if (ServoR !== e)
        $display("FAIL servo_r k=%0d: got %b want %b", k, ServoR, e);
      else passed++;
      total++;
      if (ModInfoL !== mq[0])
        $display("FAIL modinfo_l k=%0d: got %b want %b", k, ModInfoL, mq[0]);
      else passed++;
      total++;
      if (ModInfoR !== mq[1])
        $display("FAIL modinfo_r k=%0d: got %b want %b", k, ModInfoR, mq[1]);
      else passed++;
      e = !pf[CmdChan];
      total++;
      if (CmdReady !== e)
        $display("FAIL cmd_ready k=%0d: got %b want %b", k, CmdReady, e);
      else passed++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic advance_to(input int m, input int v);
    repeat ((((v - k % m) % m) + m) % m) tick();
  endtask

  task automatic test_reset();
    int n;
    int ps;
    int first;
    RST_n = 1'b0;
    CmdValid = 1'b0;
    CmdChan = 1'b0;
    CmdModInfo = '0;
    PulseL = 21'd50;
    PulseR = 21'd50;
    repeat (3) tick();
    #1;
    total++;
    if (ServoL !== 1'b0 || ServoR !== 1'b0)
      $display("FAIL rst_servo: got %b%b want 00", ServoL, ServoR);
    else passed++;
    total++;
    if (State !== 5'd0 || PeriodStart !== 1'b0)
      $display("FAIL rst_state: got %0d/%b want 0/0", State, PeriodStart);
    else passed++;
    total++;
    if (ModInfoL !== 5'b00001 || ModInfoR !== 5'b00001)
      $display("FAIL rst_modinfo: got %b %b want 00001", ModInfoL, ModInfoR);
    else passed++;
    CmdChan = 1'b1;
    #1;
    total++;
    if (CmdReady !== 1'b1)
      $display("FAIL rst_ready_r: got %b want 1", CmdReady);
    else passed++;
    CmdChan = 1'b0;
    RST_n = 1'b1;
    mon_en = 1'b1;
    n = 0;
    ps = 0;
    first = -1;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge CLK);
      if (ServoL === 1'b1) begin
        n++;
        if (first < 0) first = i;
      end
      if (PeriodStart === 1'b1) ps++;
    end
    total++;
    if (n !== 2 * NEU)
      $display("FAIL neutral_width: got %0d want %0d", n, 2 * NEU);
    else passed++;
    total++;
    if (first !== LEAD)
      $display("FAIL servo_rise: got %0d want %0d", first, LEAD);
    else passed++;
    total++;
    if (ps !== 1)
      $display("FAIL period_strobes: got %0d want 1", ps);
    else passed++;
  endtask

  task automatic test_frame_cmd();
    int kb;
    tick();
    advance_to(FR, P + 10);
    ka = k;
    CmdValid = 1'b1;
    CmdChan = 1'b0;
    CmdModInfo = 5'b01100;
    tick();
    CmdValid = 1'b0;
    #1;
    total++;
    if (CmdReady !== 1'b0)
      $display("FAIL ready_l_full: got %b want 0", CmdReady);
    else passed++;
    CmdChan = 1'b1;
    #1;
    total++;
    if (CmdReady !== 1'b1)
      $display("FAIL ready_r_free: got %b want 1", CmdReady);
    else passed++;
    CmdChan = 1'b0;
    kb = (ka / FR + 1) * FR - 1;
    repeat (kb - k) tick();
    total++;
    if (ModInfoL !== 5'b00001)
      $display("FAIL l_before_boundary: got %b want 00001", ModInfoL);
    else passed++;
    tick();
    total++;
    if (ModInfoL !== 5'b01100 || ModInfoR !== 5'b00001)
      $display("FAIL l_at_boundary: got %b %b want 01100 00001", ModInfoL, ModInfoR);
    else passed++;
  endtask

  task automatic test_watchdog();
    int kt;
    int kb;
    kt = (ka / P + 1) * P - 1 + (TMO - 1) * P;
    repeat (kt - k) tick();
    total++;
    if (ModInfoL !== 5'b01100)
      $display("FAIL wd_before: got %b want 01100", ModInfoL);
    else passed++;
    CmdValid = 1'b1;
    CmdChan = 1'b0;
    CmdModInfo = 5'b10110;
    tick();
    CmdValid = 1'b0;
    total++;
    if (ModInfoL !== 5'b00001 || CmdReady !== 1'b0)
      $display("FAIL wd_fire: got %b rdy %b want 00001 rdy 0", ModInfoL, CmdReady);
    else passed++;
    kb = (kt / FR + 1) * FR - 1;
    repeat (kb - k) tick();
    total++;
    if (ModInfoL !== 5'b00001)
      $display("FAIL wd_hold: got %b want 00001", ModInfoL);
    else passed++;
    tick();
    total++;
    if (ModInfoL !== 5'b10110)
      $display("FAIL wd_reload: got %b want 10110", ModInfoL);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int kb;
    advance_to(FR, 20);
    kb = (k / FR + 1) * FR - 1;
    CmdValid = 1'b1;
    CmdChan = 1'b0;
    CmdModInfo = 5'b11100;
    tick();
    CmdModInfo = 5'b10001;
    total++;
    if (CmdReady !== 1'b0)
      $display("FAIL b2b_ready_l: got %b want 0", CmdReady);
    else passed++;
    CmdChan = 1'b1;
    #1;
    total++;
    if (CmdReady !== 1'b1)
      $display("FAIL b2b_ready_r: got %b want 1", CmdReady);
    else passed++;
    CmdChan = 1'b0;
    repeat (kb - k) tick();
    total++;
    if (CmdReady !== 1'b0 || ModInfoL !== 5'b10110)
      $display("FAIL b2b_held: rdy %b mod %b want 0 10110", CmdReady, ModInfoL);
    else passed++;
    tick();
    total++;
    if (CmdReady !== 1'b1 || ModInfoL !== 5'b11100)
      $display("FAIL b2b_first: rdy %b mod %b want 1 11100", CmdReady, ModInfoL);
    else passed++;
    tick();
    CmdValid = 1'b0;
    total++;
    if (CmdReady !== 1'b0 || ModInfoL !== 5'b11100)
      $display("FAIL b2b_second_acc: rdy %b mod %b want 0 11100", CmdReady, ModInfoL);
    else passed++;
    repeat (kb + FR + 1 - k) tick();
    total++;
    if (ModInfoL !== 5'b10001)
      $display("FAIL b2b_second: got %b want 10001", ModInfoL);
    else passed++;
    advance_to(FR, FR - 1);
    CmdValid = 1'b1;
    CmdChan = 1'b1;
    CmdModInfo = 5'b01010;
    tick();
    CmdValid = 1'b0;
    total++;
    if (ModInfoR !== 5'b01010 || CmdReady !== 1'b1)
      $display("FAIL direct_r: mod %b rdy %b want 01010 1", ModInfoR, CmdReady);
    else passed++;
    CmdChan = 1'b0;
  endtask

  task automatic test_clamp();
    logic [20:0] vl [3];
    logic [20:0] vr [3];
    int el [3];
    int er [3];
    int nl;
    int nr;
    vl = '{21'd10, 21'd200, 21'd60};
    vr = '{21'h1FFFFF, 21'h100014, 21'd5};
    el = '{20, 80, 60};
    er = '{80, 80, 20};
    for (int i = 0; i < 3; i++) begin
      advance_to(P, 0);
      PulseL = vl[i];
      PulseR = vr[i];
      nl = 0;
      nr = 0;
      for (int j = 0; j < P; j++) begin
        @(negedge CLK);
        if (ServoL === 1'b1) nl++;
        if (ServoR === 1'b1) nr++;
        if (j == 20) begin
          PulseL = 21'($urandom);
          PulseR = 21'($urandom);
        end
      end
      total++;
      if (nl !== el[i])
        $display("FAIL clamp_l[%0d]: got %0d want %0d", i, nl, el[i]);
      else passed++;
      total++;
      if (nr !== er[i])
        $display("FAIL clamp_r[%0d]: got %0d want %0d", i, nr, er[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick();
      CmdValid = ($urandom % 4) == 0;
      CmdChan = 1'($urandom);
      CmdModInfo = 5'($urandom);
      if ($urandom % 40 == 0) PulseL = 21'($urandom);
      else PulseL = 21'($urandom_range(0, 100));
      PulseR = 21'($urandom_range(0, 100));
    end
    tick();
    CmdValid = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      PulseL = 21'($urandom_range(0, 100));
      PulseR = 21'($urandom_range(0, 100));
    end
    total++;
    if (ModInfoL !== 5'b00001 || ModInfoR !== 5'b00001)
      $display("FAIL idle_neutral: got %b %b want 00001", ModInfoL, ModInfoR);
    else passed++;
    CmdChan = 1'b1;
    #1;
    total++;
    if (CmdReady !== 1'b1)
      $display("FAIL idle_ready_r: got %b want 1", CmdReady);
    else passed++;
    CmdChan = 1'b0;
  endtask

  task automatic test_midreset();
    PulseL = 21'd50;
    PulseR = 21'd50;
    tick();
    advance_to(P, 0);
    advance_to(P, 20);
    CmdValid = 1'b1;
    CmdChan = 1'b1;
    CmdModInfo = 5'b11000;
    tick();
    CmdValid = 1'b0;
    advance_to(P, 30);
    total++;
    if (ServoL !== 1'b1 || CmdReady !== 1'b0)
      $display("FAIL pre_reset: servo %b rdy %b want 1 0", ServoL, CmdReady);
    else passed++;
    RST_n = 1'b0;
    #1;
    total++;
    if (ServoL !== 1'b0 || ServoR !== 1'b0)
      $display("FAIL async_servo: got %b%b want 00", ServoL, ServoR);
    else passed++;
    total++;
    if (CmdReady !== 1'b1 || ModInfoR !== 5'b00001 || ModInfoL !== 5'b00001)
      $display("FAIL async_cmd: rdy %b mod %b %b want 1 00001", CmdReady, ModInfoL, ModInfoR);
    else passed++;
    total++;
    if (State !== 5'd0 || PeriodStart !== 1'b0)
      $display("FAIL async_state: got %0d/%b want 0/0", State, PeriodStart);
    else passed++;
    CmdChan = 1'b0;
    repeat (2) tick();
    RST_n = 1'b1;
    repeat (P + 10) tick();
  endtask

  initial begin
    RST_n = 1'b0;
    test_reset();
    test_frame_cmd();
    test_watchdog();
    test_back_to_back();
    test_clamp();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
